// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states,
// access-size codes and the latency counter width.
package mem_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    // MEM_LAT is capped at 15, so four bits always hold MEM_LAT-1
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACCESS = ACCESS,
        ST_DONE   = DONE
    } state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the port
// that was not granted last time wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win,
    output logic valid
);
    assign valid = req0 | req1;
    assign win   = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between the CPU (port 0) and a DMA
// master (port 1), sequences a fixed-latency access and pulses done.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             win;
    logic             valid;

    rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .win   (win),
        .valid (valid)
    );

    // Grants are the only outputs decoded straight from state and owner
    assign gnt0 = (state == ST_ACCESS || state == ST_DONE) && !owner;
    assign gnt1 = (state == ST_ACCESS || state == ST_DONE) &&  owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= SZ_WORD;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        owner     <= win;
                        cnt       <= CNT_INIT;
                        mem_en    <= 1'b1;
                        mem_we    <= win ? we1    : we0;
                        mem_size  <= win ? size1  : size0;
                        mem_addr  <= win ? addr1  : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        if (!mem_we)
                            rdata <= mem_rdata;
                        mem_en <= 1'b0;
                        done0  <= !owner;
                        done1  <= owner;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    last  <= owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-timeline model of the arbiter.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [1:0]  size0, size1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic        gnt0, gnt1, done0, done1, mem_en, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] rdata, mem_addr, mem_wdata;

    logic        b_req;
    logic [31:0] b_addr, b_mrd;
    logic        b_gnt0, b_gnt1, b_done0, b_done1, b_en, b_we;
    logic [1:0]  b_size;
    logic [31:0] b_rdata, b_maddr, b_wdata;

    int passed, total;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .size0(2'b00), .size1(2'b00), .addr0(b_addr), .addr1(32'h0),
        .wdata0(32'h0), .wdata1(32'h0),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
        .rdata(b_rdata), .mem_en(b_en), .mem_we(b_we), .mem_size(b_size),
        .mem_addr(b_maddr), .mem_wdata(b_wdata), .mem_rdata(b_mrd)
    );

    // Model: an access is a timeline of phases counted in edges since its grant
    bit          m_busy, m_own, m_last, m_we;
    int          m_ph;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_last = 1; m_we = 0; m_ph = 0;
        m_size = 2'b00; m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    endtask

    task automatic model_edge();
        if (!m_busy) begin
            if (req0 || req1) begin
                m_own   = (req0 && req1) ? !m_last : req1;
                m_busy  = 1;
                m_ph    = 0;
                m_we    = m_own ? we1 : we0;
                m_size  = m_own ? size1 : size0;
                m_addr  = m_own ? addr1 : addr0;
                m_wdata = m_own ? wdata1 : wdata0;
            end
        end else begin
            m_ph++;
            if (m_ph == L && !m_we) m_rdata = mem_rdata;
            if (m_ph == L + 1) begin
                m_busy = 0;
                m_last = m_own;
            end
        end
    endtask

    function automatic bit mdone(input bit p);
        return m_busy && m_ph == L && m_own == p;
    endfunction

    function automatic logic [103:0] obs();
        return {gnt0, gnt1, done0, done1, mem_en, mem_we, mem_size, mem_addr, mem_wdata, rdata};
    endfunction

    function automatic logic [103:0] expv();
        bit d;
        d = m_busy && m_ph == L;
        return {m_busy && !m_own, m_busy && m_own, d && !m_own, d && m_own,
                m_busy && m_ph < L, m_we, m_size, m_addr, m_wdata, m_rdata};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; size0 = 0; size1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
        b_req = 0; b_addr = 0; b_mrd = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== expv()) $display("FAIL reset_state: got %h exp %h", obs(), expv());
        else passed++;
        total++;
        if ({b_gnt0, b_gnt1, b_done0, b_en, b_rdata} !== 36'h0)
            $display("FAIL reset_state_lat1: got %h exp 0", {b_gnt0, b_gnt1, b_done0, b_en, b_rdata});
        else passed++;
        rst_n = 1;
    endtask

    task automatic test_cpu_read();
        req0 = 1; we0 = 0; size0 = 2'b00; addr0 = 32'h10; wdata0 = 32'h0;
        mem_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (obs() !== expv()) $display("FAIL cpu_read_vec c%0d: got %h exp %h", k, obs(), expv());
            else passed++;
            total++;
            if (mem_en !== (k < L) || (k < L && mem_addr !== 32'h10))
                $display("FAIL cpu_read_en c%0d: got en=%b addr=%h", k, mem_en, mem_addr);
            else passed++;
            total++;
            if (done0 !== (k == L) || gnt1 !== 1'b0)
                $display("FAIL cpu_read_done c%0d: got done0=%b gnt1=%b exp done0=%b gnt1=0", k, done0, gnt1, k == L);
            else passed++;
            if (k == L) begin
                total++;
                if (rdata !== 32'hDEADBEEF) $display("FAIL cpu_read_data: got %h exp deadbeef", rdata);
                else passed++;
            end
            if (mdone(0)) req0 = 0;
        end
    endtask

    task automatic test_tie_alternate();
        bit order[$];
        int when[$];
        logic [3:0] seq;
        rst_n = 0; #1; rst_n = 1;
        model_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h100; addr1 = 32'h104;
        for (int k = 0; k < 4 * (L + 2); k++) begin
            step();
            total++;
            if (obs() !== expv()) $display("FAIL tie_vec c%0d: got %h exp %h", k, obs(), expv());
            else passed++;
            if (done0) begin order.push_back(1'b0); when.push_back(k); end
            if (done1) begin order.push_back(1'b1); when.push_back(k); end
            mem_rdata = $urandom;
        end
        req0 = 0; req1 = 0;
        seq = 4'hF;
        if (order.size() == 4) seq = {order[0], order[1], order[2], order[3]};
        total++;
        if (seq !== 4'b0101) $display("FAIL tie_order: got %b (%0d dones) exp 0101", seq, order.size());
        else passed++;
        total++;
        if (when.size() < 2 || when[1] - when[0] != L + 2)
            $display("FAIL tie_spacing: got %0d dones, exp gap %0d", when.size(), L + 2);
        else passed++;
    endtask

    task automatic test_dma_write();
        logic [31:0] prev;
        prev = m_rdata;
        req0 = 0; req1 = 1; we1 = 1; size1 = 2'b01; addr1 = 32'h200; wdata1 = 32'h12345678;
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (obs() !== expv()) $display("FAIL dma_wr_vec c%0d: got %h exp %h", k, obs(), expv());
            else passed++;
            if (k < L) begin
                total++;
                if ({mem_en, mem_we, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'b01, 32'h200, 32'h12345678})
                    $display("FAIL dma_wr_fields c%0d: got en=%b we=%b sz=%b a=%h d=%h", k, mem_en, mem_we, mem_size, mem_addr, mem_wdata);
                else passed++;
            end
            if (k == L) begin
                total++;
                if (done1 !== 1'b1 || rdata !== prev)
                    $display("FAIL dma_wr_done: got done1=%b rdata=%h exp 1 %h", done1, rdata, prev);
                else passed++;
            end
            if (mdone(1)) req1 = 0;
        end
        we1 = 0;
    endtask

    task automatic test_reset_mid_access();
        req0 = 1; we0 = 0; size0 = 2'b10; addr0 = 32'h44;
        step();
        step();
        total++;
        if (obs() !== expv()) $display("FAIL rst_mid_pre: got %h exp %h", obs(), expv());
        else passed++;
        rst_n = 0;
        #1;
        total++;
        if ({mem_en, gnt0, done0} !== 3'b000) $display("FAIL rst_mid_abort: got %b exp 000", {mem_en, gnt0, done0});
        else passed++;
        model_reset();
        req0 = 0; req1 = 1; we1 = 0; size1 = 2'b00; addr1 = 32'h300;
        #1 rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (obs() !== expv()) $display("FAIL rst_mid_vec c%0d: got %h exp %h", k, obs(), expv());
            else passed++;
            if (k == 0) begin
                total++;
                if (gnt1 !== 1'b1 || gnt0 !== 1'b0) $display("FAIL rst_mid_gnt1: got gnt0=%b gnt1=%b exp 0 1", gnt0, gnt1);
                else passed++;
            end
            if (mdone(1)) req1 = 0;
            mem_rdata = $urandom;
        end
    endtask

    task automatic test_lat1();
        logic [31:0] at_edge, exp_rd;
        exp_rd = 32'h0;
        b_req = 1; b_addr = 32'h80; b_mrd = $urandom;
        for (int k = 0; k < 9; k++) begin
            at_edge = b_mrd;
            step();
            if (k % 3 == 1) exp_rd = at_edge;
            total++;
            if (b_done0 !== (k % 3 == 1) || b_en !== (k % 3 == 0) || b_rdata !== exp_rd)
                $display("FAIL lat1 c%0d: got done=%b en=%b rdata=%h exp %b %b %h",
                         k, b_done0, b_en, b_rdata, k % 3 == 1, k % 3 == 0, exp_rd);
            else passed++;
            b_mrd = $urandom;
        end
        b_req = 0;
    endtask

    task automatic test_reissue();
        int n, dones;
        n = 0; dones = 0;
        req0 = 1; we0 = 0; size0 = 2'b00; addr0 = 32'h20;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (obs() !== expv()) $display("FAIL reissue_vec c%0d: got %h exp %h", k, obs(), expv());
            else passed++;
            if (done0) dones++;
            if (mdone(0)) begin
                n++;
                if (n == 2) req0 = 0;
            end
            mem_rdata = $urandom;
        end
        total++;
        if (dones != 2) $display("FAIL reissue_count: got %0d dones exp 2", dones);
        else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step();
            total++;
            if (obs() !== expv()) $display("FAIL random_vec c%0d: got %h exp %h", k, obs(), expv());
            else passed++;
            if (req0) begin
                if (mdone(0) && $urandom_range(0, 3) != 0) req0 = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                req0 = 1; we0 = 1'($urandom_range(0, 1)); size0 = 2'($urandom_range(0, 2));
                addr0 = $urandom; wdata0 = $urandom;
            end
            if (req1) begin
                if (mdone(1) && $urandom_range(0, 3) != 0) req1 = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                req1 = 1; we1 = 1'($urandom_range(0, 1)); size1 = 2'($urandom_range(0, 2));
                addr1 = $urandom; wdata1 = $urandom;
            end
            mem_rdata = $urandom;
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_cpu_read();
        test_tie_alternate();
        test_dma_write();
        test_reset_mid_access();
        test_lat1();
        test_reissue();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
